// File: rtl/hack_screen_scanner.sv
// HACK screen raster reader: fetches screen words in address order and shifts them out as a paced
// 1-bit pixel stream. Define HACK_SCREEN_INVERT_EN to invert the pixel polarity (1 = white).
module hack_screen_scanner #(
  parameter int H_WORDS = 32,
  parameter int V_LINES = 256,
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              line_start,
  output logic              frame_start,
  output logic              underrun
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int COL_W = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_WORDS * V_LINES - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_WORDS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(V_LINES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(WORD_W);

`ifdef HACK_SCREEN_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   buf_q, buf_d, sh_q, sh_d;
  logic                buf_full_q, buf_full_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                pixel_q, pixel_d, pv_q, pv_d, ls_q, ls_d, fs_q, fs_d, ur_q, ur_d;

  logic                wr, use_buf, take, buf_left, refill;
  logic [WORD_W-1:0]   eff_w, rem_w;
  logic [CNT_W-1:0]    eff_c, rem_c;

  // Fetch FSM; rst gates mem_rd so the request is quiet while held in reset.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mem_rd  = 1'b0;
    wr      = 1'b0;
    case (state_q)
      S_IDLE: if (!buf_full_q && !rst) begin
        mem_rd  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (mem_valid) begin
        wr      = 1'b1;
        addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An empty shifter sees the buffer word directly, so reload and consume share one cycle.
  always_comb begin
    use_buf    = (cnt_q == '0) && buf_full_q;
    eff_w      = use_buf ? buf_q : sh_q;
    eff_c      = use_buf ? FULL_CNT : cnt_q;
    take       = pix_en && (eff_c != '0);
    rem_c      = eff_c - CNT_W'(take);
    rem_w      = take ? (eff_w >> 1) : eff_w;
    buf_left   = buf_full_q && !use_buf;
    refill     = (rem_c == '0) && buf_left;
    sh_d       = refill ? buf_q : rem_w;
    cnt_d      = refill ? FULL_CNT : rem_c;
    buf_full_d = (buf_left && !refill) || wr;
    buf_d      = wr ? mem_data : buf_q;

    pixel_d = take ? (eff_w[0] ^ INV) : pixel_q;
    pv_d    = take;
    ls_d    = take && (eff_c == FULL_CNT) && (col_q == '0);
    fs_d    = ls_d && (row_q == '0);
    ur_d    = ur_q || (pix_en && (eff_c == '0));

    col_d = col_q;
    row_d = row_q;
    if (take && (eff_c == CNT_W'(1))) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      pixel_q    <= 1'b0;
      pv_q       <= 1'b0;
      ls_q       <= 1'b0;
      fs_q       <= 1'b0;
      ur_q       <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pixel_q    <= pixel_d;
      pv_q       <= pv_d;
      ls_q       <= ls_d;
      fs_q       <= fs_d;
      ur_q       <= ur_d;
    end
  end

  assign mem_addr    = addr_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pv_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_hack_screen_scanner.sv
// Bench for hack_screen_scanner: small raster geometry, latency-programmable memory responder and a
// raster-index reference model that predicts every pixel, line/frame flag and read address.
module tb_hack_screen_scanner;
  localparam int H = 8, V = 4, WW = 16, AW = 13;
  localparam int FRAME = H * V, PPL = H * WW, PPF = FRAME * WW;
`ifdef HACK_SCREEN_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
  logic          mem_rd, mem_valid, pixel, pixel_valid, line_start, frame_start, underrun;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_data;
  logic [WW-1:0] mem [FRAME];
  logic          cap [1024];
  int            n_assert = 0, n_fail = 0;
  int            lat = 1;
  logic          stale_now = 1'b0;
  int            p = 0, rdk = 0, ls_cnt = 0, fs_cnt = 0;

  hack_screen_scanner #(.H_WORDS(H), .V_LINES(V), .WORD_W(WW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_valid(mem_valid), .pixel(pixel), .pixel_valid(pixel_valid),
    .line_start(line_start), .frame_start(frame_start), .underrun(underrun));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pv(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (pixel_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, pixel_valid, 1);
  endtask

  task automatic wait_rd(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (mem_rd !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, mem_rd, 1);
  endtask

  // Memory: one outstanding read, data returned lat cycles after the request is seen.
  initial begin : responder
    int            cnt;
    logic          pend;
    logic [AW-1:0] pa;
    cnt = 0; pend = 1'b0; pa = '0;
    mem_valid = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (rst) pend = 1'b0;
      else begin
        if (stale_now) begin
          mem_valid = 1'b1;
          mem_data  = '1;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mem_valid = 1'b1;
            mem_data  = mem[int'(pa) % FRAME];
            pend      = 1'b0;
          end
        end else if (mem_rd) begin
          pa = mem_addr; pend = 1'b1; cnt = lat;
        end
      end
    end
  end

  // Reference model: pixel p of the stream is bit p%16 of word (p/16) mod frame size.
  initial begin : monitor
    logic [WW-1:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        p = 0; rdk = 0; ls_cnt = 0; fs_cnt = 0;
      end else begin
        if (mem_rd) begin
          check("rd_addr", 32'(mem_addr), rdk % FRAME);
          rdk++;
        end
        if (pixel_valid) begin
          w = mem[(p / WW) % FRAME];
          check("pixel", pixel, w[p % WW] ^ INV);
          check("line_start", line_start, (p % PPL) == 0);
          check("frame_start", frame_start, (p % PPF) == 0);
          if (line_start) ls_cnt++;
          if (frame_start) fs_cnt++;
          if (p < 1024) cap[p] = pixel;
          p++;
        end
      end
    end
  end

  initial begin : main
    int            gaps, p0;
    logic [WW-1:0] pat;
    for (int i = 0; i < FRAME; i++) mem[i] = WW'($urandom);
    mem[0] = 16'h0001;
    mem[5] = 16'hA5A5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_pixel", pixel, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_line_start", line_start, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun, 0);

    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("first_rd", mem_rd, 1);
    check("first_rd_addr", 32'(mem_addr), 0);
    @(negedge clk);
    check("rd_single_outstanding", mem_rd, 0);
    wait_rd("second_rd_seen");
    check("second_rd_addr", 32'(mem_addr), 1);

    @(posedge clk); #1 pix_en = 1'b1;
    wait_pv("first_pv_seen");
    check("first_pixel", pixel, 1'b1 ^ INV);
    check("first_line_start", line_start, 1);
    check("first_frame_start", frame_start, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("word0_pv", pixel_valid, 1);
      check("word0_pixel", pixel, INV);
    end

    gaps = 0;
    repeat (600) begin
      @(negedge clk);
      if (pixel_valid !== 1'b1) gaps++;
    end
    check("no_bubble", gaps, 0);
    pat = 16'hA5A5 ^ {WW{INV}};
    for (int i = 0; i < 16; i++) check("a5a5_pixel", cap[80 + i], pat[i]);
    check("stream_underrun", underrun, 0);

    repeat (3000) begin
      @(posedge clk); #1;
      pix_en = 1'($urandom_range(0, 1));
      lat    = $urandom_range(1, 3);
    end
    @(posedge clk); #1 pix_en = 1'b0;
    repeat (5) @(negedge clk);
    check("random_underrun", underrun, 0);
    check("frame_wrapped", p > 2 * PPF, 1);
    check("line_start_count", ls_cnt, (p + PPL - 1) / PPL);
    check("frame_start_count", fs_cnt, (p + PPF - 1) / PPF);

    @(posedge clk); #1 lat = 40; pix_en = 1'b1;
    repeat (300) @(negedge clk);
    check("slow_underrun_set", underrun, 1);
    p0 = p;
    repeat (300) @(negedge clk);
    check("slow_underrun_sticky", underrun, 1);
    check("slow_progress", p > p0, 1);

    lat = 5;
    wait_rd("pre_reset_rd_seen");
    @(posedge clk); #1 rst = 1'b1; pix_en = 1'b0;
    repeat (3) @(negedge clk);
    check("midrd_rst_underrun", underrun, 0);
    check("midrd_rst_addr", 32'(mem_addr), 0);
    check("midrd_rst_mem_rd", mem_rd, 0);
    check("midrd_rst_pv", pixel_valid, 0);

    // A stale strobe of all-ones lands while the fresh request is just being issued.
    @(posedge clk); #1 rst = 1'b0; lat = 1; stale_now = 1'b1;
    @(negedge clk);
    check("restart_rd", mem_rd, 1);
    check("restart_addr", 32'(mem_addr), 0);
    @(posedge clk); #1 stale_now = 1'b0;
    repeat (3) @(posedge clk);
    #1 pix_en = 1'b1;
    wait_pv("restart_pv_seen");
    check("restart_pixel", pixel, mem[0][0] ^ INV);
    check("restart_frame_start", frame_start, 1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("restart_word_pixel", pixel, mem[0][i] ^ INV);
    end
    check("restart_underrun", underrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
